bottom_mux: RTL and testbench



---
 rtl/bottom_mux.sv | 90 +++++++++
 tb/tb_bottom_mux.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bottom_mux.sv
`default_nettype none
// ============================================================================
//  Module   : bottom_mux
//  Purpose  : 2-to-1 word multiplexer (MIPS write-register index select,
//             rt vs rd). Combinational result y plus a registered copy y_q
//             with load enable and a valid flag for pipelined consumers.
//  Options  : BOTTOM_MUX_SEL_COUNT_EN adds sel_b_count, a saturating count
//             of enabled loads that picked input b.
//  Revision : 1.0  initial release
// ============================================================================
module bottom_mux #(
  parameter int unsigned          WIDTH   = 5,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
`ifdef BOTTOM_MUX_SEL_COUNT_EN
  output logic [15:0]      sel_b_count,
`endif
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             q_valid
);

  logic [WIDTH-1:0] y_q_d;
  logic [WIDTH-1:0] y_q_q;
  logic             q_valid_d;
  logic             q_valid_q;

  // Combinational select; an unknown sel merges a and b bitwise in simulation.
  always_comb begin
    y = sel ? b : a;
  end

  // Next-state for the registered copy: load on en, otherwise hold.
  always_comb begin
    y_q_d     = y_q_q;
    q_valid_d = q_valid_q;
    if (en) begin
      y_q_d     = y;
      q_valid_d = 1'b1;
    end
  end

  // Registered copy; reset takes priority over the load enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_q     <= RST_VAL;
      q_valid_q <= 1'b0;
    end else begin
      y_q_q     <= y_q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign y_q     = y_q_q;
  assign q_valid = q_valid_q;

`ifdef BOTTOM_MUX_SEL_COUNT_EN
  logic [15:0] sel_b_count_d;
  logic [15:0] sel_b_count_q;

  // Count enabled loads that chose b; an unknown sel is not treated as b.
  always_comb begin
    sel_b_count_d = sel_b_count_q;
    if (en && (sel == 1'b1) && (sel_b_count_q != 16'hFFFF)) begin
      sel_b_count_d = sel_b_count_q + 16'd1;
    end
  end

  // Counter state, cleared by reset, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_b_count_q <= 16'd0;
    end else begin
      sel_b_count_q <= sel_b_count_d;
    end
  end

  assign sel_b_count = sel_b_count_q;
`else
  // Selection counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_bottom_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bottom_mux
//  Purpose  : Self-checking bench for bottom_mux (combinational select,
//             unknown-select merge, registered load/hold, reset priority and
//             the optional BOTTOM_MUX_SEL_COUNT_EN counter).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bottom_mux;

  localparam int unsigned WIDTH = 5;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             q_valid;
`ifdef BOTTOM_MUX_SEL_COUNT_EN
  logic [15:0]      sel_b_count;
`endif

  bottom_mux #(.WIDTH(WIDTH), .RST_VAL('0)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .sel        (sel),
    .en         (en),
`ifdef BOTTOM_MUX_SEL_COUNT_EN
    .sel_b_count(sel_b_count),
`endif
    .y          (y),
    .y_q        (y_q),
    .q_valid    (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] y_q;
    logic             v;
    logic [15:0]      cnt;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_yq;
  logic             m_v;
  logic [15:0]      m_cnt;
  int               errors;
  int               checks;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one clock of stimulus, predict the registered outputs, compare after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic s,
                      input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    exp_t x;
    rst = r; en = e; sel = s; a = aa; b = bb;
    if (r) begin
      m_yq = '0; m_v = 1'b0; m_cnt = 16'd0;
    end else if (e) begin
      m_yq = s ? bb : aa;
      m_v  = 1'b1;
      if (s === 1'b1 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    x.y_q = m_yq; x.v = m_v; x.cnt = m_cnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: scoreboard empty observed=%0d expected=1", tag, sb.size());
    end else begin
      x = sb.pop_front();
      chk({tag, ".y_q"}, {11'd0, y_q}, {11'd0, x.y_q});
      chk({tag, ".q_valid"}, {15'd0, q_valid}, {15'd0, x.v});
`ifdef BOTTOM_MUX_SEL_COUNT_EN
      chk({tag, ".count"}, sel_b_count, x.cnt);
`endif
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    m_yq = '0; m_v = 1'b0; m_cnt = 16'd0;
    rst = 1'b1; en = 1'b0; sel = 1'b0; a = '0; b = '0;

    // Reset state
    step("reset", 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000);

    // Combinational paths, no edge needed
    rst = 1'b0; en = 1'b0;
    a = 5'b01010; b = 5'b10101; sel = 1'b1; #1;
    chk("comb_sel_b", {11'd0, y}, {11'd0, 5'b10101});
    a = 5'b00101; b = 5'b11101; sel = 1'b0; #1;
    chk("comb_sel_a", {11'd0, y}, {11'd0, 5'b00101});
    b = 5'b11111; #1;
    chk("comb_sel_a_b_change", {11'd0, y}, {11'd0, 5'b00101});
    a = 5'b00101; b = 5'b11101; sel = 1'bx; #1;
    chk("comb_sel_x_merge", {11'd0, y}, {11'd0, 5'bxx101});
    a = 5'b00000; b = 5'b00000; #1;
    chk("comb_sel_x_agree", {11'd0, y}, {11'd0, 5'b00000});
    sel = 1'b0;

    // Registered load and hold
    step("load_b", 1'b0, 1'b1, 1'b1, 5'b00000, 5'b10101);
    step("hold", 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000);
    chk("comb_during_hold", {11'd0, y}, {11'd0, 5'b00000});

    // Reset wins over enable; y keeps tracking inputs
    step("rst_over_en", 1'b1, 1'b1, 1'b1, 5'b01100, 5'b10101);
    chk("comb_during_rst", {11'd0, y}, {11'd0, 5'b10101});
    step("valid_stays_low", 1'b0, 1'b0, 1'b1, 5'b01100, 5'b10011);
    step("load_a", 1'b0, 1'b1, 1'b0, 5'b01100, 5'b10011);

    // Counter sequence (registered outputs checked in every build)
    step("cnt_rst", 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000);
    step("cnt_b1", 1'b0, 1'b1, 1'b1, 5'b00001, 5'b11110);
    step("cnt_b2", 1'b0, 1'b1, 1'b1, 5'b00010, 5'b11101);
    step("cnt_b3", 1'b0, 1'b1, 1'b1, 5'b00011, 5'b11100);
    step("cnt_a1", 1'b0, 1'b1, 1'b0, 5'b00100, 5'b11011);
    step("cnt_a2", 1'b0, 1'b1, 1'b0, 5'b00101, 5'b11010);
    step("cnt_selx", 1'b0, 1'b1, 1'bx, 5'b00101, 5'b11101);
    step("cnt_hold_b", 1'b0, 1'b0, 1'b1, 5'b00000, 5'b11111);
`ifdef BOTTOM_MUX_SEL_COUNT_EN
    chk("cnt_equals_3", sel_b_count, 16'd3);
`endif
    step("cnt_clear", 1'b1, 1'b1, 1'b1, 5'b00000, 5'b11111);
`ifdef BOTTOM_MUX_SEL_COUNT_EN
    chk("cnt_cleared", sel_b_count, 16'd0);
`endif

    if (sb.size() != 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
